mem_stage_lsu: RTL and testbench

//  Load/store unit for the MEM pipeline stage. It sits directly upstream of the byte-addressed data memory.
//  - Accepts load/store requests from EX over a valid/ready handshake.
//  - Buffers stores in a small FIFO and drains them to memory on idle port cycles.
//  - Issues loads with priority over store drain. A load that hits a buffered store waits for the drain.
//  - Returns load data, zero-extended for byte loads, to WB tagged with the destination register.

---
 rtl/mem_stage_lsu_if.sv | 47 ++++
 rtl/mem_stage_lsu.sv | 206 ++++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_lsu_if.sv
// mem_stage_lsu_if
//   Bundles the LSU's request, response and data-memory buses.
//   slave  : the LSU side (takes requests from EX, drives WB response and memory).
//   master : the environment side (EX request source, WB sink, data memory).
// Signals
//   req_valid/req_ready/req_write/req_byte/req_addr/req_wdata/req_rd : EX request
//   resp_valid/resp_data/resp_rd/resp_err/err_pulse                  : WB response
//   mem_addr/mem_wdata/mem_re/mem_we/mem_byte/mem_rdata               : data memory
//   sb_empty                                                          : store buffer empty
interface mem_stage_lsu_if #(
  parameter int N = 32
);
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic         req_byte;
  logic [N-1:0] req_addr;
  logic [N-1:0] req_wdata;
  logic [3:0]   req_rd;

  logic         resp_valid;
  logic [N-1:0] resp_data;
  logic [3:0]   resp_rd;
  logic         resp_err;
  logic         err_pulse;

  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  logic         mem_re;
  logic         mem_we;
  logic         mem_byte;
  logic [N-1:0] mem_rdata;

  logic         sb_empty;

  modport slave (
    input  req_valid, req_write, req_byte, req_addr, req_wdata, req_rd, mem_rdata,
    output req_ready, resp_valid, resp_data, resp_rd, resp_err, err_pulse,
           mem_addr, mem_wdata, mem_re, mem_we, mem_byte, sb_empty
  );

  modport master (
    output req_valid, req_write, req_byte, req_addr, req_wdata, req_rd, mem_rdata,
    input  req_ready, resp_valid, resp_data, resp_rd, resp_err, err_pulse,
           mem_addr, mem_wdata, mem_re, mem_we, mem_byte, sb_empty
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu
//   MEM-stage load/store unit in front of a byte-addressed data memory.
//   Stores are buffered in a small FIFO and drained on cycles where no read
//   is issued; loads go to memory first unless they alias a buffered store,
//   in which case they wait until every aliasing entry has drained.
// Ports
//   clk    : clock, all state updates on posedge
//   rst_n  : asynchronous active-low reset
//   bus    : mem_stage_lsu_if.slave (EX request, WB response, memory, sb_empty)
// Parameters
//   N        data/address width
//   ADDR_W   address bits used for the load/store alias compare
//   SB_DEPTH store-buffer entries (power of 2, >= 2)
module mem_stage_lsu #(
  parameter int N        = 32,
  parameter int ADDR_W   = 12,
  parameter int SB_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_stage_lsu_if.slave bus
);
  localparam int PTR_W = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LD_WAIT  = 2'd1,
    LD_ISSUE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [N-1:0]        sb_addr [SB_DEPTH];
  logic [N-1:0]        sb_data [SB_DEPTH];
  logic [SB_DEPTH-1:0] sb_byte;
  logic [SB_DEPTH-1:0] sb_vld;
  logic [PTR_W-1:0]    head;
  logic [PTR_W-1:0]    tail;
  logic [CNT_W-1:0]    count;

  logic [N-1:0] ld_addr;
  logic         ld_byte;
  logic [3:0]   ld_rd;

  logic         accept;
  logic         misaligned;
  logic         ld_accept;
  logic         st_push;
  logic         req_hazard;
  logic         wait_hazard;
  logic         issue_rd;
  logic         latch_ld;
  logic         drain;
  logic [N-1:0] rd_addr;
  logic         rd_byte;

  // Ready is held low while in reset so no transfer can be seen during it.
  assign bus.req_ready = rst_n && (state == IDLE) && (count < CNT_W'(SB_DEPTH));
  assign bus.sb_empty  = (count == '0);

  assign accept     = bus.req_valid && bus.req_ready;
  assign misaligned = !bus.req_byte && (bus.req_addr[1:0] != 2'b00);
  assign ld_accept  = accept && !bus.req_write && !misaligned;
  assign st_push    = accept && bus.req_write && !misaligned;

  // Alias check on word index: a byte store anywhere in the word blocks a
  // word load and vice versa. Per-slot valid bits avoid head/count arithmetic.
  always_comb begin
    req_hazard  = 1'b0;
    wait_hazard = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (sb_vld[i] && (sb_addr[i][ADDR_W-1:2] == bus.req_addr[ADDR_W-1:2]))
        req_hazard = 1'b1;
      if (sb_vld[i] && (sb_addr[i][ADDR_W-1:2] == ld_addr[ADDR_W-1:2]))
        wait_hazard = 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    issue_rd   = 1'b0;
    latch_ld   = 1'b0;
    rd_addr    = ld_addr;
    rd_byte    = ld_byte;
    case (state)
      IDLE: begin
        if (ld_accept) begin
          latch_ld = 1'b1;
          if (req_hazard) begin
            state_next = LD_WAIT;
          end else begin
            issue_rd   = 1'b1;
            rd_addr    = bus.req_addr;
            rd_byte    = bus.req_byte;
            state_next = LD_ISSUE;
          end
        end
      end
      LD_WAIT: begin
        if (!wait_hazard) begin
          issue_rd   = 1'b1;
          state_next = LD_ISSUE;
        end
      end
      LD_ISSUE: state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // The memory port is shared: the drain only uses it when no read goes out.
  assign drain = !issue_rd && (count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      sb_vld <= '0;
    end else begin
      if (drain) begin
        sb_vld[head] <= 1'b0;
        head         <= head + PTR_W'(1);
      end
      if (st_push) begin
        sb_vld[tail] <= 1'b1;
        tail         <= tail + PTR_W'(1);
      end
      if (st_push && !drain)      count <= count + CNT_W'(1);
      else if (!st_push && drain) count <= count - CNT_W'(1);
    end
  end

  // Payload storage needs no reset; sb_vld and count say what is live.
  always_ff @(posedge clk) begin
    if (st_push) begin
      sb_addr[tail] <= bus.req_addr;
      sb_data[tail] <= bus.req_wdata;
      sb_byte[tail] <= bus.req_byte;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_addr <= '0;
      ld_byte <= 1'b0;
      ld_rd   <= '0;
    end else if (latch_ld) begin
      ld_addr <= bus.req_addr;
      ld_byte <= bus.req_byte;
      ld_rd   <= bus.req_rd;
    end
  end

  // Address/data/size only change when an access is actually issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_re    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_byte  <= 1'b0;
    end else begin
      bus.mem_re <= issue_rd;
      bus.mem_we <= drain;
      if (issue_rd) begin
        bus.mem_addr <= rd_addr;
        bus.mem_byte <= rd_byte;
      end else if (drain) begin
        bus.mem_addr  <= sb_addr[head];
        bus.mem_wdata <= sb_data[head];
        bus.mem_byte  <= sb_byte[head];
      end
    end
  end

  // Misaligned requests answer in the cycle after acceptance without touching
  // memory; normal loads answer from LD_ISSUE once mem_rdata has settled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.resp_valid <= 1'b0;
      bus.resp_data  <= '0;
      bus.resp_rd    <= '0;
      bus.resp_err   <= 1'b0;
      bus.err_pulse  <= 1'b0;
    end else begin
      bus.resp_valid <= 1'b0;
      bus.err_pulse  <= accept && misaligned;
      bus.resp_err   <= accept && misaligned;
      if (accept && misaligned && !bus.req_write) begin
        bus.resp_valid <= 1'b1;
        bus.resp_data  <= '0;
        bus.resp_rd    <= bus.req_rd;
      end else if (state == LD_ISSUE) begin
        bus.resp_valid <= 1'b1;
        bus.resp_rd    <= ld_rd;
        bus.resp_data  <= ld_byte ? {{(N-8){1'b0}}, bus.mem_rdata[7:0]} : bus.mem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu
//   Directed and random traffic into mem_stage_lsu with a behavioural data
//   memory behind it. Expected load responses are queued at acceptance and a
//   monitor pops and compares them whenever resp_valid is seen.
module tb_mem_stage_lsu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_stage_lsu_if #(.N(32)) bus ();

  mem_stage_lsu #(.N(32), .ADDR_W(12), .SB_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  rd;
    logic        err;
    int          cyc;
  } resp_t;

  resp_t       resp_q[$];
  int          err_q[$];
  int          tests = 0;
  int          fails = 0;
  int          cycle = 0;
  int          violations = 0;
  logic [7:0]  mem_model [0:4095];
  logic [7:0]  ref_mem   [0:4095];
  logic        last_we_byte = 1'b0;
  logic        last_re_byte = 1'b0;
  logic [31:0] last_we_addr = '0;
  logic [31:0] last_re_addr = '0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] refRead(input logic [11:0] a, input logic byt);
    if (byt) return {24'h0, ref_mem[a]};
    return {ref_mem[a + 12'd3], ref_mem[a + 12'd2], ref_mem[a + 12'd1], ref_mem[a]};
  endfunction

  // Data memory: samples on negedge; byte reads put junk in the upper bits so
  // the LSU's zero-extension is exercised.
  initial begin : memory_proc
    logic [11:0] a;
    forever begin
      @(negedge clk);
      a = bus.mem_addr[11:0];
      if (bus.mem_we) begin
        last_we_byte = bus.mem_byte;
        last_we_addr = bus.mem_addr;
        if (bus.mem_byte) mem_model[a] = bus.mem_wdata[7:0];
        else for (int k = 0; k < 4; k++) mem_model[a + 12'(k)] = bus.mem_wdata[8*k +: 8];
      end
      if (bus.mem_re) begin
        last_re_byte = bus.mem_byte;
        last_re_addr = bus.mem_addr;
        if (bus.mem_byte) bus.mem_rdata = {24'hFFFFFF, mem_model[a]};
        else bus.mem_rdata = {mem_model[a + 12'd3], mem_model[a + 12'd2],
                              mem_model[a + 12'd1], mem_model[a]};
      end
    end
  end

  initial begin : monitor_proc
    resp_t e;
    int    ec;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.mem_re && bus.mem_we) violations++;
        if (bus.resp_valid) begin
          if (resp_q.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL resp_unexpected: resp_valid=1 rd=%0d data=0x%08h, expected no response",
                     bus.resp_rd, bus.resp_data);
          end else begin
            e = resp_q.pop_front();
            checkOutput("resp_data", bus.resp_data, e.data);
            checkOutput("resp_rd", 32'(bus.resp_rd), 32'(e.rd));
            checkOutput("resp_err", 32'(bus.resp_err), 32'(e.err));
            if (e.cyc >= 0) checkOutput("resp_cycle", cycle, e.cyc);
          end
        end
        if (bus.err_pulse) begin
          if (err_q.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL err_unexpected: err_pulse=1 at cycle %0d, expected 0", cycle);
          end else begin
            ec = err_q.pop_front();
            checkOutput("err_cycle", cycle, ec);
            checkOutput("err_resp_err", 32'(bus.resp_err), 32'd1);
          end
        end
      end
    end
  end

  // Presents one request from posedge+1 and holds it until accepted. lat>0
  // gives the hand-computed cycles from acceptance to resp_valid; hand=1 uses
  // exp_data instead of the reference memory.
  task automatic applyStimulus(input logic wr, input logic byt, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] rd, input int lat,
                               input logic hand, input logic [31:0] exp_data, output int waited);
    resp_t e;
    int    cneg;
    logic  mis;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_byte  = byt;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_rd    = rd;
    waited = 0;
    @(negedge clk);
    while (!bus.req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.req_ready) begin
      tests++;
      fails++;
      $display("[TB] FAIL handshake: req_ready stayed 0 for %0d cycles, expected 1", waited);
      bus.req_valid = 1'b0;
      return;
    end
    cneg = cycle;
    mis  = !byt && (addr[1:0] != 2'b00);
    if (mis) begin
      err_q.push_back(cneg + 1);
      if (!wr) begin
        e.data = '0; e.rd = rd; e.err = 1'b1; e.cyc = cneg + 1;
        resp_q.push_back(e);
      end
    end else if (wr) begin
      if (byt) ref_mem[addr[11:0]] = wdata[7:0];
      else for (int k = 0; k < 4; k++) ref_mem[addr[11:0] + 12'(k)] = wdata[8*k +: 8];
    end else begin
      e.data = hand ? exp_data : refRead(addr[11:0], byt);
      e.rd   = rd;
      e.err  = 1'b0;
      e.cyc  = (lat > 0) ? cneg + 1 + lat : -1;
      resp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    bus.req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int          w;
    int          sw_waits[4];
    logic        rw, rb;
    logic [31:0] ra;

    for (int i = 0; i < 4096; i++) begin
      mem_model[i] = 8'((i * 7 + 3) & 255);
      ref_mem[i]   = 8'((i * 7 + 3) & 255);
    end
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_byte  = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_rd    = '0;

    // Reset state
    #2;
    checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("rst_resp_data", bus.resp_data, 32'd0);
    checkOutput("rst_err_pulse", 32'(bus.err_pulse), 32'd0);
    checkOutput("rst_mem_re", 32'(bus.mem_re), 32'd0);
    checkOutput("rst_mem_we", 32'(bus.mem_we), 32'd0);
    checkOutput("rst_mem_addr", bus.mem_addr, 32'd0);
    checkOutput("rst_sb_empty", 32'(bus.sb_empty), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_rst_req_ready", 32'(bus.req_ready), 32'd1);

    // 1: store then aliasing load waits one drain cycle
    applyStimulus(1'b1, 1'b0, 32'h010, 32'hDEADBEEF, 4'd0, 0, 1'b0, 32'h0, w);
    applyStimulus(1'b0, 1'b0, 32'h010, 32'h0, 4'd3, 2, 1'b1, 32'hDEADBEEF, w);
    idleCycles(3);
    checkOutput("t1_sb_empty", 32'(bus.sb_empty), 32'd1);

    // 2: byte store/load, zero extension, byte lane merge
    applyStimulus(1'b1, 1'b1, 32'h013, 32'hFFFFFFA5, 4'd0, 0, 1'b0, 32'h0, w);
    applyStimulus(1'b0, 1'b1, 32'h013, 32'h0, 4'd5, 2, 1'b1, 32'h000000A5, w);
    idleCycles(3);
    checkOutput("t2_we_byte", 32'(last_we_byte), 32'd1);
    checkOutput("t2_we_addr", last_we_addr, 32'h013);
    checkOutput("t2_re_byte", 32'(last_re_byte), 32'd1);
    checkOutput("t2_re_addr", last_re_addr, 32'h013);
    applyStimulus(1'b0, 1'b0, 32'h010, 32'h0, 4'd6, 1, 1'b1, 32'hA5ADBEEF, w);
    applyStimulus(1'b0, 1'b1, 32'h201, 32'h0, 4'd2, 1, 1'b1, 32'h0000000A, w);
    idleCycles(3);

    // 3: load goes first, then back-to-back stores, then aliasing load
    applyStimulus(1'b0, 1'b0, 32'h200, 32'h0, 4'd7, 1, 1'b1, 32'h18110A03, w);
    for (int k = 0; k < 4; k++)
      applyStimulus(1'b1, 1'b0, 32'h100 + 32'(4 * k), 32'h11111111 * 32'(k + 1), 4'd0, 0, 1'b0, 32'h0, sw_waits[k]);
    checkOutput("t3_sw0_wait", 32'(sw_waits[0]), 32'd1);
    checkOutput("t3_sw1_wait", 32'(sw_waits[1]), 32'd0);
    checkOutput("t3_sw3_wait", 32'(sw_waits[3]), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h10C, 32'h0, 4'd8, 2, 1'b1, 32'h44444444, w);
    idleCycles(3);

    // 4: misaligned load and store
    applyStimulus(1'b0, 1'b0, 32'h002, 32'h0, 4'd9, 0, 1'b1, 32'h0, w);
    checkOutput("t4_mem_re", 32'(bus.mem_re), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h006, 32'hCAFEF00D, 4'd0, 0, 1'b0, 32'h0, w);
    checkOutput("t4_sb_empty", 32'(bus.sb_empty), 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h004, 32'h0, 4'd10, 1, 1'b1, 32'h342D261F, w);
    idleCycles(3);

    // 5: reset while LD_ISSUE with a store buffered
    applyStimulus(1'b1, 1'b0, 32'h400, 32'h12345678, 4'd0, 0, 1'b0, 32'h0, w);
    applyStimulus(1'b0, 1'b0, 32'h500, 32'h0, 4'd11, 1, 1'b0, 32'h0, w);
    checkOutput("t5_pre_mem_re", 32'(bus.mem_re), 32'd1);
    checkOutput("t5_pre_sb_empty", 32'(bus.sb_empty), 32'd0);
    rst_n = 1'b0;
    resp_q.delete();
    for (int k = 0; k < 4; k++) ref_mem[12'h400 + 12'(k)] = 8'(((12'h400 + k) * 7 + 3) & 255);
    #1;
    checkOutput("t5_mem_re", 32'(bus.mem_re), 32'd0);
    checkOutput("t5_mem_we", 32'(bus.mem_we), 32'd0);
    checkOutput("t5_sb_empty", 32'(bus.sb_empty), 32'd1);
    checkOutput("t5_resp_valid", 32'(bus.resp_valid), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    idleCycles(4);

    // 6: random mixed traffic in a small window to force aliasing
    for (int k = 0; k < 60; k++) begin
      rw = 1'($urandom_range(0, 1));
      rb = ($urandom_range(0, 2) == 0);
      ra = 32'h300 + 32'($urandom_range(0, 31));
      if (!rb && $urandom_range(0, 9) != 0) ra[1:0] = 2'b00;
      applyStimulus(rw, rb, ra, $urandom, 4'($urandom_range(0, 15)), 0, 1'b0, 32'h0, w);
      if ($urandom_range(0, 3) == 0) idleCycles(1);
    end
    idleCycles(30);

    checkOutput("end_resp_q_empty", 32'(resp_q.size()), 32'd0);
    checkOutput("end_err_q_empty", 32'(err_q.size()), 32'd0);
    checkOutput("end_re_we_overlap", 32'(violations), 32'd0);
    checkOutput("end_sb_empty", 32'(bus.sb_empty), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
